// File: rtl/atmo_correction_stream.sv
// rtl/atmo_correction_stream.sv - per-lane gain/offset/saturate correction on a pixel beat stream
//
// Purpose:
//   Applies a fixed-point gain (optionally plus offset) to every pixel lane of a
//   beat. The beat moves through a two-stage pipeline (S1 multiply, S2
//   round/offset/saturate) and then into a first-word-fall-through output FIFO.
//   S1 and S2 never stall. in_ready is credit based, so a beat is accepted only
//   when the FIFO is guaranteed to have room for it.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   cfg_mode              0 bypass, 1 gain sat, 2 gain+offset sat, 3 gain wrap
//   cfg_gain              unsigned gain, FRAC_W fractional bits
//   cfg_offset            unsigned additive offset (mode 2)
//   in_valid/in_ready     input beat handshake
//   in_data/in_keep       LANES pixels of PIX_W bits, per-lane valid mask
//   in_last               frame end marker
//   out_valid/out_ready   output beat handshake
//   out_data              corrected pixels, same lane layout as in_data
//   out_wr_en/out_last    in_keep/in_last carried with the beat
//   sat_clr, sat_count    count of beats with a saturated kept lane, and its clear
//   busy                  a beat is held in S1, S2 or the FIFO

module atmo_correction_stream #(
  parameter int LANES      = 64,
  parameter int PIX_W      = 32,
  parameter int FRAC_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [1:0]               cfg_mode,
  input  logic [31:0]              cfg_gain,
  input  logic [PIX_W-1:0]         cfg_offset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES*PIX_W-1:0]   in_data,
  input  logic [LANES-1:0]         in_keep,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANES*PIX_W-1:0]   out_data,
  output logic [LANES-1:0]         out_wr_en,
  output logic                     out_last,
  input  logic                     sat_clr,
  output logic [15:0]              sat_count,
  output logic                     busy
);

  localparam int DATA_W = LANES * PIX_W;
  localparam int PROD_W = PIX_W + 32;
  // Two spare bits: one for the rounding add, one for the offset add.
  localparam int EXT_W  = PROD_W + 2;
  localparam int AW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW     = AW + 2;

  localparam logic [EXT_W-1:0] RND  = EXT_W'(1) << (FRAC_W - 1);
  localparam logic [EXT_W-1:0] MAXV = EXT_W'({PIX_W{1'b1}});

  // ---------------------------------------------------------------------------
  // Input credit
  // ---------------------------------------------------------------------------
  // ready_en holds in_ready low while rst_n is low and releases it on the
  // first clock edge after reset is removed.
  logic          ready_en;
  logic          accept;
  logic [CW-1:0] occupancy;

  logic          s1_valid;
  logic          s2_valid;
  logic [AW:0]   fifo_count;

  // Everything already committed downstream counts against FIFO space, so a
  // beat entering S1 always finds a free FIFO slot two edges later.
  assign occupancy = CW'(fifo_count) + CW'(s1_valid) + CW'(s2_valid);
  assign in_ready  = ready_en && (occupancy < CW'(FIFO_DEPTH));
  assign accept    = in_valid && in_ready;

  // ---------------------------------------------------------------------------
  // S1: multiply, capturing the configuration together with the beat
  // ---------------------------------------------------------------------------
  logic [1:0]        s1_mode;
  logic [PIX_W-1:0]  s1_offset;
  logic [LANES-1:0]  s1_keep;
  logic              s1_last;
  logic [PIX_W-1:0]  s1_pix  [LANES];
  logic [PROD_W-1:0] s1_prod [LANES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en <= 1'b0;
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      s1_valid <= accept;
      s2_valid <= s1_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      s1_mode   <= cfg_mode;
      s1_offset <= cfg_offset;
      s1_keep   <= in_keep;
      s1_last   <= in_last;
      for (int i = 0; i < LANES; i++) begin
        s1_pix[i]  <= in_data[i*PIX_W +: PIX_W];
        s1_prod[i] <= PROD_W'(in_data[i*PIX_W +: PIX_W]) * PROD_W'(cfg_gain);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // S2: round half up, optional offset, clamp or wrap
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] s2_next_data;
  logic [LANES-1:0]  lane_sat;
  logic [EXT_W-1:0]  sum_v;
  logic [EXT_W-1:0]  rnd_v;
  logic [EXT_W-1:0]  off_v;

  always_comb begin
    s2_next_data = '0;
    lane_sat     = '0;
    sum_v        = '0;
    rnd_v        = '0;
    off_v        = '0;
    for (int i = 0; i < LANES; i++) begin
      sum_v = EXT_W'(s1_prod[i]) + RND;
      rnd_v = sum_v >> FRAC_W;
      off_v = rnd_v + EXT_W'(s1_offset);
      case (s1_mode)
        2'd0: s2_next_data[i*PIX_W +: PIX_W] = s1_pix[i];
        2'd1: begin
          if (rnd_v > MAXV) begin
            s2_next_data[i*PIX_W +: PIX_W] = {PIX_W{1'b1}};
            lane_sat[i]                    = 1'b1;
          end else begin
            s2_next_data[i*PIX_W +: PIX_W] = rnd_v[PIX_W-1:0];
          end
        end
        2'd2: begin
          if (off_v > MAXV) begin
            s2_next_data[i*PIX_W +: PIX_W] = {PIX_W{1'b1}};
            lane_sat[i]                    = 1'b1;
          end else begin
            s2_next_data[i*PIX_W +: PIX_W] = off_v[PIX_W-1:0];
          end
        end
        default: s2_next_data[i*PIX_W +: PIX_W] = rnd_v[PIX_W-1:0];
      endcase
    end
  end

  logic [DATA_W-1:0] s2_data;
  logic [LANES-1:0]  s2_keep;
  logic              s2_last;
  logic              s2_sat;

  // Lanes with keep=0 are still computed, but only kept lanes flag saturation.
  always_ff @(posedge clk) begin
    if (s1_valid) begin
      s2_data <= s2_next_data;
      s2_keep <= s1_keep;
      s2_last <= s1_last;
      s2_sat  <= |(lane_sat & s1_keep);
    end
  end

  // ---------------------------------------------------------------------------
  // Output FIFO (first-word fall-through)
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
  logic [LANES-1:0]  fifo_keep [FIFO_DEPTH];
  logic              fifo_last [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              fifo_wr;
  logic              fifo_rd;

  // S2 always writes; the input credit guarantees there is room.
  assign fifo_wr = s2_valid;
  assign fifo_rd = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (fifo_wr) wr_ptr <= wr_ptr + AW'(1);
      if (fifo_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({fifo_wr, fifo_rd})
        2'b10:   fifo_count <= fifo_count + (AW+1)'(1);
        2'b01:   fifo_count <= fifo_count - (AW+1)'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_wr) begin
      fifo_data[wr_ptr] <= s2_data;
      fifo_keep[wr_ptr] <= s2_keep;
      fifo_last[wr_ptr] <= s2_last;
    end
  end

  // The storage is not reset, so the head entry is masked while empty.
  assign out_valid = (fifo_count != '0);
  assign out_data  = out_valid ? fifo_data[rd_ptr] : '0;
  assign out_wr_en = out_valid ? fifo_keep[rd_ptr] : '0;
  assign out_last  = out_valid ? fifo_last[rd_ptr] : 1'b0;

  // ---------------------------------------------------------------------------
  // Saturation counter and status
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_count <= '0;
    end else if (sat_clr) begin
      sat_count <= '0;
    end else if (fifo_wr && s2_sat && (sat_count != 16'hFFFF)) begin
      sat_count <= sat_count + 16'd1;
    end
  end

  assign busy = s1_valid || s2_valid || (fifo_count != '0);

endmodule
